// File: rtl/blackjack_pkg.sv
// Shared BlackJack definitions: deal sequencer state encoding and the
// state-to-output decode used to build its registered Moore outputs.
package blackjack_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DEAL  = 3'd1,
        ST_CLEAR = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } deal_state_e;

    typedef struct packed {
        logic rst_counter;
        logic act_counter;
        logic deal_pulse;
        logic busy;
        logic done;
    } deal_outs_t;

    function automatic deal_outs_t decode_outputs(input deal_state_e st);
        deal_outs_t o;
        o = '{rst_counter: 1'b0, act_counter: 1'b0, deal_pulse: 1'b0,
              busy: 1'b0, done: 1'b0};
        case (st)
            ST_IDLE:  o.busy = 1'b0;
            ST_DEAL:  begin o.deal_pulse  = 1'b1; o.busy = 1'b1; end
            ST_CLEAR: begin o.rst_counter = 1'b1; o.busy = 1'b1; end
            ST_WAIT:  begin o.act_counter = 1'b1; o.busy = 1'b1; end
            ST_DONE:  begin o.done        = 1'b1; o.busy = 1'b1; end
            default:  o.busy = 1'b0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/deal_sequencer.sv
// Deals N_CARDS cards one at a time, pausing for the external 2 s Counter
// after each card. Outputs are registered from the next state.
module deal_sequencer
    import blackjack_pkg::*;
#(
    parameter int N_CARDS   = 4,
    parameter int IDX_WIDTH = 3
) (
    input  logic                 clk_2K,
    input  logic                 i_Reset,
    input  logic                 i_Start,
    input  logic                 i_Abort,
    input  logic                 i_TwoSec,
    output logic                 o_RstCounter,
    output logic                 o_ActCounter,
    output logic                 o_DealPulse,
    output logic [IDX_WIDTH-1:0] o_CardIdx,
    output logic                 o_Busy,
    output logic                 o_Done
);

    deal_state_e          state_r;
    deal_state_e          state_nx_s;
    logic [IDX_WIDTH-1:0] idx_r;
    logic [IDX_WIDTH-1:0] idx_nx_s;
    logic                 wait_first_r;
    deal_outs_t           outs_r;

    // Next-state and card-count logic; abort from any busy state wins over everything.
    always_comb begin
        state_nx_s = state_r;
        idx_nx_s   = idx_r;
        if (i_Abort && (state_r != ST_IDLE)) begin
            state_nx_s = ST_IDLE;
            idx_nx_s   = {IDX_WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_Start && !i_Abort) begin
                        state_nx_s = ST_DEAL;
                        idx_nx_s   = {IDX_WIDTH{1'b0}};
                    end else begin
                        state_nx_s = ST_IDLE;
                    end
                end
                ST_DEAL: begin
                    state_nx_s = ST_CLEAR;
                    idx_nx_s   = idx_r + IDX_WIDTH'(1);
                end
                ST_CLEAR: state_nx_s = ST_WAIT;
                ST_WAIT: begin
                    // The first WAIT cycle may still see a flag from before the clear.
                    if (!wait_first_r && i_TwoSec) begin
                        if (idx_r == IDX_WIDTH'(N_CARDS)) begin
                            state_nx_s = ST_DONE;
                        end else begin
                            state_nx_s = ST_DEAL;
                        end
                    end else begin
                        state_nx_s = ST_WAIT;
                    end
                end
                ST_DONE: state_nx_s = ST_IDLE;
                default: state_nx_s = ST_IDLE;
            endcase
        end
    end

    // State, card index, first-wait flag and output registers.
    always_ff @(posedge clk_2K or negedge i_Reset) begin
        if (!i_Reset) begin
            state_r      <= ST_IDLE;
            idx_r        <= {IDX_WIDTH{1'b0}};
            wait_first_r <= 1'b0;
            outs_r       <= decode_outputs(ST_IDLE);
        end else begin
            state_r      <= state_nx_s;
            idx_r        <= idx_nx_s;
            wait_first_r <= (state_nx_s == ST_WAIT) && (state_r != ST_WAIT);
            outs_r       <= decode_outputs(state_nx_s);
        end
    end

    assign o_RstCounter = outs_r.rst_counter;
    assign o_ActCounter = outs_r.act_counter;
    assign o_DealPulse  = outs_r.deal_pulse;
    assign o_Busy       = outs_r.busy;
    assign o_Done       = outs_r.done;
    assign o_CardIdx    = idx_r;

endmodule

// File: tb/tb_deal_sequencer.sv
// Directed bench for deal_sequencer with a stub of the 2 s Counter
// (flag rises 5 cycles after enable, drops on clear).
module tb_deal_sequencer;

    logic       clk_2K = 1'b0;
    logic       i_Reset = 1'b0;
    logic       i_Start = 1'b0;
    logic       i_Abort = 1'b0;
    logic       i_TwoSec;
    logic       o_RstCounter;
    logic       o_ActCounter;
    logic       o_DealPulse;
    logic [2:0] o_CardIdx;
    logic       o_Busy;
    logic       o_Done;

    logic stub_ts  = 1'b0;
    logic force_ts = 1'b0;
    int   stub_cnt = 0;

    int checks = 0;
    int errors = 0;
    int deal_cnt = 0;
    int rst_cnt = 0;
    int done_cnt = 0;
    int overlap_cnt = 0;

    assign i_TwoSec = stub_ts | force_ts;

    deal_sequencer #(.N_CARDS(4), .IDX_WIDTH(3)) dut (
        .clk_2K      (clk_2K),
        .i_Reset     (i_Reset),
        .i_Start     (i_Start),
        .i_Abort     (i_Abort),
        .i_TwoSec    (i_TwoSec),
        .o_RstCounter(o_RstCounter),
        .o_ActCounter(o_ActCounter),
        .o_DealPulse (o_DealPulse),
        .o_CardIdx   (o_CardIdx),
        .o_Busy      (o_Busy),
        .o_Done      (o_Done)
    );

    always #5 clk_2K = ~clk_2K;

    // Counter stub.
    always @(negedge clk_2K) begin
        if (o_RstCounter) begin
            stub_cnt = 0;
            stub_ts  = 1'b0;
        end else if (o_ActCounter) begin
            stub_cnt = stub_cnt + 1;
            if (stub_cnt >= 5) stub_ts = 1'b1;
        end
    end

    // Event counters, sampled at the edge that ends each cycle.
    always @(posedge clk_2K) begin
        if (o_DealPulse) deal_cnt = deal_cnt + 1;
        if (o_RstCounter) rst_cnt = rst_cnt + 1;
        if (o_Done) done_cnt = done_cnt + 1;
        if (o_RstCounter && o_ActCounter) overlap_cnt = overlap_cnt + 1;
    end

    task automatic pulse_start();
        i_Start = 1'b1;
        @(negedge clk_2K);
        i_Start = 1'b0;
    endtask

    task automatic test_reset();
        i_Reset = 1'b0;
        repeat (3) @(negedge clk_2K);
        checks++;
        if ({o_RstCounter, o_ActCounter, o_DealPulse, o_Busy, o_Done, o_CardIdx} !== 8'h00) begin
            errors++;
            $display("FAIL reset_hold: outputs=%b idx=%0d, required all 0",
                     {o_RstCounter, o_ActCounter, o_DealPulse, o_Busy, o_Done}, o_CardIdx);
        end
        i_Reset = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_2K);
            checks++;
            if ({o_RstCounter, o_ActCounter, o_DealPulse, o_Busy, o_Done, o_CardIdx} !== 8'h00) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: outputs=%b idx=%0d, required all 0", c,
                         {o_RstCounter, o_ActCounter, o_DealPulse, o_Busy, o_Done}, o_CardIdx);
            end
        end
    endtask

    task automatic test_full_deal();
        int d0, r0, n0, exp_idx, cyc, done_cyc, busy_err;
        bit seen_done;
        d0 = deal_cnt; r0 = rst_cnt; n0 = done_cnt;
        pulse_start();
        checks++;
        if (o_DealPulse !== 1'b1 || o_Busy !== 1'b1) begin
            errors++;
            $display("FAIL first_deal: deal=%b busy=%b, required 1 1", o_DealPulse, o_Busy);
        end
        @(negedge clk_2K);
        checks++;
        if ({o_RstCounter, o_ActCounter, o_DealPulse} !== 3'b100 || o_CardIdx !== 3'd1) begin
            errors++;
            $display("FAIL first_clear: rst/act/deal=%b idx=%0d, required 100 idx 1",
                     {o_RstCounter, o_ActCounter, o_DealPulse}, o_CardIdx);
        end
        @(negedge clk_2K);
        checks++;
        if ({o_RstCounter, o_ActCounter, o_DealPulse} !== 3'b010) begin
            errors++;
            $display("FAIL first_wait: rst/act/deal=%b, required 010",
                     {o_RstCounter, o_ActCounter, o_DealPulse});
        end
        exp_idx = 2; cyc = 3; seen_done = 1'b0; done_cyc = 0; busy_err = 0;
        for (int c = 0; c < 200 && !seen_done; c++) begin
            @(negedge clk_2K);
            cyc++;
            if (!o_Busy) busy_err++;
            if (o_RstCounter) begin
                checks++;
                if (o_CardIdx !== 3'(exp_idx)) begin
                    errors++;
                    $display("FAIL card_idx_step: idx=%0d, required %0d", o_CardIdx, exp_idx);
                end
                exp_idx++;
            end
            if (o_Done) begin
                seen_done = 1'b1;
                done_cyc  = cyc;
            end
        end
        checks++;
        if (!seen_done) begin
            errors++;
            $display("FAIL done_timeout: no o_Done within 200 cycles, required one");
        end
        checks++;
        if (done_cyc != 29) begin
            errors++;
            $display("FAIL done_timing: done in cycle %0d, required 29", done_cyc);
        end
        checks++;
        if (busy_err != 0) begin
            errors++;
            $display("FAIL busy_throughout: %0d cycles with busy low, required 0", busy_err);
        end
        checks++;
        if (exp_idx != 5) begin
            errors++;
            $display("FAIL clear_count_idx: reached %0d, required 5", exp_idx);
        end
        @(negedge clk_2K);
        checks++;
        if ({o_RstCounter, o_ActCounter, o_DealPulse, o_Busy, o_Done} !== 5'b0 || o_CardIdx !== 3'd4) begin
            errors++;
            $display("FAIL idle_after_done: outputs=%b idx=%0d, required 00000 idx 4",
                     {o_RstCounter, o_ActCounter, o_DealPulse, o_Busy, o_Done}, o_CardIdx);
        end
        checks++;
        if (deal_cnt - d0 != 4 || rst_cnt - r0 != 4 || done_cnt - n0 != 1) begin
            errors++;
            $display("FAIL full_deal_counts: deals=%0d clears=%0d dones=%0d, required 4 4 1",
                     deal_cnt - d0, rst_cnt - r0, done_cnt - n0);
        end
    endtask

    task automatic test_stale_flag();
        i_Start = 1'b1;
        @(negedge clk_2K);
        i_Start  = 1'b0;
        force_ts = 1'b1;
        @(negedge clk_2K);
        @(negedge clk_2K);
        checks++;
        if (o_ActCounter !== 1'b1) begin
            errors++;
            $display("FAIL stale_wait1: act=%b, required 1", o_ActCounter);
        end
        @(negedge clk_2K);
        checks++;
        if (o_ActCounter !== 1'b1 || o_DealPulse !== 1'b0) begin
            errors++;
            $display("FAIL stale_wait2: act=%b deal=%b, required 1 0", o_ActCounter, o_DealPulse);
        end
        @(negedge clk_2K);
        checks++;
        if (o_DealPulse !== 1'b1 || o_ActCounter !== 1'b0 || o_CardIdx !== 3'd1) begin
            errors++;
            $display("FAIL stale_advance: deal=%b act=%b idx=%0d, required 1 0 1",
                     o_DealPulse, o_ActCounter, o_CardIdx);
        end
        i_Abort  = 1'b1;
        force_ts = 1'b0;
        @(negedge clk_2K);
        i_Abort = 1'b0;
        checks++;
        if ({o_RstCounter, o_ActCounter, o_DealPulse, o_Busy, o_Done} !== 5'b0 || o_CardIdx !== 3'd0) begin
            errors++;
            $display("FAIL abort_in_deal: outputs=%b idx=%0d, required 00000 idx 0",
                     {o_RstCounter, o_ActCounter, o_DealPulse, o_Busy, o_Done}, o_CardIdx);
        end
    endtask

    task automatic test_abort_wait2();
        int d0, n0;
        bit found;
        d0 = deal_cnt; n0 = done_cnt; found = 1'b0;
        pulse_start();
        for (int c = 0; c < 100 && !found; c++) begin
            if (o_RstCounter && o_CardIdx == 3'd2) found = 1'b1;
            else @(negedge clk_2K);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL abort_reach_card2: second clear not seen, required within 100 cycles");
            return;
        end
        repeat (5) @(negedge clk_2K);
        checks++;
        if (o_ActCounter !== 1'b1) begin
            errors++;
            $display("FAIL abort_wait5: act=%b, required 1", o_ActCounter);
        end
        i_Abort = 1'b1;
        @(negedge clk_2K);
        i_Abort = 1'b0;
        checks++;
        if ({o_RstCounter, o_ActCounter, o_DealPulse, o_Busy, o_Done} !== 5'b0 || o_CardIdx !== 3'd0) begin
            errors++;
            $display("FAIL abort_in_wait: outputs=%b idx=%0d, required 00000 idx 0",
                     {o_RstCounter, o_ActCounter, o_DealPulse, o_Busy, o_Done}, o_CardIdx);
        end
        repeat (20) @(negedge clk_2K);
        checks++;
        if (deal_cnt - d0 != 2 || done_cnt - n0 != 0) begin
            errors++;
            $display("FAIL abort_quiet: deals=%0d dones=%0d, required 2 0",
                     deal_cnt - d0, done_cnt - n0);
        end
    endtask

    task automatic test_start_while_busy();
        int d0, n0;
        bit found, seen_done;
        d0 = deal_cnt; n0 = done_cnt; found = 1'b0; seen_done = 1'b0;
        pulse_start();
        for (int c = 0; c < 100 && !found; c++) begin
            if (o_RstCounter && o_CardIdx == 3'd3) found = 1'b1;
            else @(negedge clk_2K);
        end
        i_Start = 1'b1;
        @(negedge clk_2K);
        i_Start = 1'b0;
        for (int c = 0; c < 200 && !seen_done; c++) begin
            @(negedge clk_2K);
            if (o_Done) seen_done = 1'b1;
        end
        checks++;
        if (!found || !seen_done) begin
            errors++;
            $display("FAIL busy_start_progress: card3=%b done=%b, required 1 1", found, seen_done);
        end
        @(negedge clk_2K);
        checks++;
        if (deal_cnt - d0 != 4 || done_cnt - n0 != 1 || o_Busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_ignored: deals=%0d dones=%0d busy=%b, required 4 1 0",
                     deal_cnt - d0, done_cnt - n0, o_Busy);
        end
        i_Start = 1'b1;
        i_Abort = 1'b1;
        repeat (5) @(negedge clk_2K);
        checks++;
        if ({o_RstCounter, o_ActCounter, o_DealPulse, o_Busy, o_Done} !== 5'b0 || o_CardIdx !== 3'd4) begin
            errors++;
            $display("FAIL start_with_abort: outputs=%b idx=%0d, required 00000 idx 4",
                     {o_RstCounter, o_ActCounter, o_DealPulse, o_Busy, o_Done}, o_CardIdx);
        end
        i_Start = 1'b0;
        i_Abort = 1'b0;
        repeat (3) @(negedge clk_2K);
        checks++;
        if (deal_cnt - d0 != 4) begin
            errors++;
            $display("FAIL start_with_abort_deals: deals=%0d, required 4", deal_cnt - d0);
        end
    endtask

    task automatic test_async_reset();
        int d0, bad;
        bit found;
        d0 = deal_cnt; found = 1'b0; bad = 0;
        pulse_start();
        for (int c = 0; c < 20 && !found; c++) begin
            if (o_RstCounter) found = 1'b1;
            else @(negedge clk_2K);
        end
        #2;
        i_Reset = 1'b0;
        #1;
        checks++;
        if (!found || {o_RstCounter, o_ActCounter, o_DealPulse, o_Busy, o_Done, o_CardIdx} !== 8'h00) begin
            errors++;
            $display("FAIL async_reset: in_clear=%b outputs=%b idx=%0d, required 1 00000 idx 0", found,
                     {o_RstCounter, o_ActCounter, o_DealPulse, o_Busy, o_Done}, o_CardIdx);
        end
        @(negedge clk_2K);
        i_Reset = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_2K);
            if (o_Busy || o_DealPulse) bad++;
        end
        checks++;
        if (bad != 0 || deal_cnt - d0 != 1) begin
            errors++;
            $display("FAIL no_resume: busy cycles=%0d deals=%0d, required 0 1", bad, deal_cnt - d0);
        end
    endtask

    task automatic test_no_overlap();
        checks++;
        if (overlap_cnt != 0) begin
            errors++;
            $display("FAIL rst_act_overlap: %0d cycles, required 0", overlap_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_full_deal();
        test_stale_flag();
        test_abort_wait2();
        test_start_while_busy();
        test_async_reset();
        test_no_overlap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
